alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that computes a wide add/subtract using one narrow ripple-carry adder slice (SLICE_W bits), one slice per clock, LSB slice first.
- Carry is registered between slices.
- Sits between the ALU operand/opcode registers and the shared rc_adder instance. Drives the slice's a/b/mode/c_in and collects sum/c_out.
- Lets a small adder serve a full-width ALU datapath.

Parameters:
- SLICE_W, 2, bit width of the external adder slice.
- NUM_SLICES, 4, slices per operation; operand width W = SLICE_W*NUM_SLICES (default 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when busy=0.
- mode  in  1  0 = add (a+b), 1 = subtract (a-b); latched on accepted start.
- a  in  W  operand A; latched on accepted start.
- b  in  W  operand B; latched on accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result/c_out/overflow valid and updated.
- result  out  W  sum/difference; holds until next completion.
- c_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow of final result.
- slice_a  out  SLICE_W  current A slice to adder.
- slice_b  out  SLICE_W  current B slice to adder, uninverted; the adder applies mode.
- slice_mode  out  1  latched mode to adder.
- slice_c_in  out  1  carry into current slice.
- slice_sum  in  SLICE_W  adder sum, combinational from slice_* outputs.
- slice_c_out  in  1  adder carry out.

Behaviour:
- Reset, synchronous, any state: state=IDLE, busy=0, done=0, result=0, c_out=0, overflow=0, slice index=0, carry register=0, latched operands/mode=0. Aborts an operation mid-flight with no done pulse.
- FSM states: IDLE, RUN.
- IDLE:
  - busy=0.
  - On an edge with start=1: latch a, b, mode; idx<=0; carry<=mode (or c_in, see Optional Feature); go RUN, busy<=1.
- RUN, each cycle:
  - slice_a = A[idx*SLICE_W +: SLICE_W]; slice_b = B[same]; slice_mode = mode; slice_c_in = carry.
  - On the edge: acc[idx slice]<=slice_sum; carry<=slice_c_out; idx<=idx+1.
- Completion, on the edge where idx==NUM_SLICES-1:
  - result<=acc with the final slice merged; c_out<=slice_c_out.
  - overflow<=(A[W-1]==Beff[W-1]) && (res[W-1]!=A[W-1]), where Beff=mode?~B:B.
  - done<=1, busy<=0, go IDLE.
- Latency:
  - done rises exactly NUM_SLICES edges after the edge that sampled start.
  - Throughput is one op per NUM_SLICES+1 cycles if start is held. A start is accepted on the edge where done is high, because state is IDLE then.
- start while busy=1 is ignored; it is neither queued nor able to corrupt latched operands.
- Input a/b/mode changes during RUN have no effect.
- result/c_out/overflow change only on completion edges or reset. Intermediate slice results are never visible.
- idx has no wrap past NUM_SLICES-1; index width is clog2(NUM_SLICES), minimum 1.
- In IDLE, slice_* outputs are driven from the latched registers with slice_c_in=carry. They are stable but don't-care.

Optional Feature:
- Macro ALU_SEQ_CARRYIN_EN.
- Defined:
  - Adds input port c_in (1 bit), latched on accepted start.
  - The first-slice carry is c_in instead of mode. This allows chained multi-precision add-with-carry and subtract-with-borrow (caller supplies c_in=1 for plain subtract).
- Undefined: no c_in port; first-slice carry equals mode (0 for add, 1 for two's-complement subtract).

Test Plan (W=8, SLICE_W=2, NUM_SLICES=4, macro undefined unless noted):
1. Add: a=0x5A, b=0x33, mode=0, 1-cycle start → done pulses 4 edges later, one cycle wide; result=0x8D, c_out=0, overflow=1; busy high exactly 4 cycles.
2. Wrap: a=0xFF, b=0x01, mode=0 → result=0x00, c_out=1, overflow=0. Then a=0x10, b=0x01, mode=1 → result=0x0F, c_out=1, overflow=0.
3. Signed subtract overflow: a=0x80, b=0x01, mode=1 → result=0x7F, c_out=1, overflow=1. Also a=0x00, b=0x01, mode=1 → result=0xFF, c_out=0, overflow=0.
4. Start during busy: start a=0x01+0x01, then pulse start with a=0xF0 two cycles later → single done, result=0x02; a second done does not occur without a new start after busy falls.
5. Reset mid-op: start 0x5A+0x33, assert rst on the 2nd RUN cycle → next edge busy=0, done=0, result=0x00, c_out=0, overflow=0; no done pulse follows. A fresh start then completes normally.
6. ALU_SEQ_CARRYIN_EN defined: a=0x7F, b=0x00, mode=0, c_in=1 → result=0x80, c_out=0, overflow=1. Also a=0x10, b=0x01, mode=1, c_in=0 → result=0x0E, c_out=1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle wide add/subtract built from one external SLICE_W-bit adder slice, LSB slice first.
// Optional macro ALU_SEQ_CARRYIN_EN adds a c_in port that supplies the first-slice carry.
module alu_seq_ctrl #(
   parameter int SLICE_W    = 2,
   parameter int NUM_SLICES = 4,
   localparam int W         = SLICE_W * NUM_SLICES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
`ifdef ALU_SEQ_CARRYIN_EN
   input  logic               c_in,
`endif
   output logic               busy,
   output logic               done,
   output logic [W-1:0]       result,
   output logic               c_out,
   output logic               overflow,
   output logic [SLICE_W-1:0] slice_a,
   output logic [SLICE_W-1:0] slice_b,
   output logic               slice_mode,
   output logic               slice_c_in,
   input  logic [SLICE_W-1:0] slice_sum,
   input  logic               slice_c_out
);

   localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             mode_q, mode_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     result_q, result_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             first_carry;
   logic             b_eff_msb;

`ifdef ALU_SEQ_CARRYIN_EN
   assign first_carry = c_in;
`else
   assign first_carry = mode;
`endif

   // The slice always sees the latched operands, so input changes mid-run are harmless.
   assign slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
   assign slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
   assign slice_mode = mode_q;
   assign slice_c_in = carry_q;
   assign b_eff_msb  = mode_q ? ~b_q[W-1] : b_q[W-1];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      acc_d    = acc_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               mode_d  = mode;
               idx_d   = '0;
               carry_d = first_carry;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
            carry_d = slice_c_out;
            if (idx_q == LAST_IDX) begin
               // acc_d already holds the final slice, so commit it directly.
               result_d = acc_d;
               c_out_d  = slice_c_out;
               ovf_d    = (a_q[W-1] == b_eff_msb) && (acc_d[W-1] != a_q[W-1]);
               done_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mode_q   <= mode_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign result   = result_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;

endmodule
